// File: rtl/bu2_pipe_cfg_if.sv
// Butterfly bus: operand/control inputs from the coefficient read port,
// results plus pass-through twiddle/modulus toward write-back.
interface bu2_pipe_cfg_if #(
    parameter int DW = 16
);
    logic          in_valid;
    logic [DW-1:0] in1;
    logic [DW-1:0] in2;
    logic [DW-1:0] twiddle;
    logic [DW-1:0] modulus;
    logic          mode;
    logic          div2;
    logic          stall;
    logic          BU_valid;
    logic [DW-1:0] fft_a;
    logic [DW-1:0] fft_b;
    logic [DW-1:0] twiddle_BU_out;
    logic [DW-1:0] modulus_BU_out;

    modport master (
        output in_valid, in1, in2, twiddle, modulus, mode, div2, stall,
        input  BU_valid, fft_a, fft_b, twiddle_BU_out, modulus_BU_out
    );

    modport slave (
        input  in_valid, in1, in2, twiddle, modulus, mode, div2, stall,
        output BU_valid, fft_a, fft_b, twiddle_BU_out, modulus_BU_out
    );
endinterface

// File: rtl/bu2_pipe_cfg.sv
// Four-stage radix-2 modular butterfly (CT forward / GS inverse with optional
// halving); one butterfly per non-stalled cycle, global stall freezes all stages.
module bu2_pipe_cfg #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    bu2_pipe_cfg_if.slave bus
);
    typedef struct packed {
        logic          mode;
        logic          div2;
        logic [DW-1:0] w;
        logic [DW-1:0] q;
    } ctrl_t;

    // x/2 mod q for odd q: an odd x is made even by adding q before shifting.
    function automatic logic [DW-1:0] half_mod(input logic [DW-1:0] x, input logic [DW-1:0] q);
        logic [DW:0] t;
        t = x[0] ? ({1'b0, x} + {1'b0, q}) : {1'b0, x};
        return DW'(t >> 1);
    endfunction

    logic            v1_q, v2_q, v3_q, out_v_q;
    ctrl_t           c1_q, c2_q, c3_q;
    logic [DW-1:0]   a1_q, b1_q;
    logic [DW-1:0]   x2_d, x2_q;
    logic [2*DW-1:0] p2_d, p2_q;
    logic [DW-1:0]   x3_q;
    logic [DW-1:0]   r3_d, r3_q;
    logic [DW-1:0]   fa_d, fa_q, fb_d, fb_q, tw_q, md_q;

    logic [DW:0]     sum2, dif2;
    logic [DW-1:0]   s2, d2;

    // NOTE: every variable in a combinational block is assigned on every path, so no latch is inferred.
    always_comb begin
        sum2 = {1'b0, a1_q} + {1'b0, b1_q};
        s2   = (sum2 >= {1'b0, c1_q.q}) ? DW'(sum2 - {1'b0, c1_q.q}) : sum2[DW-1:0];
        dif2 = {1'b0, a1_q} - {1'b0, b1_q};
        d2   = dif2[DW] ? DW'(dif2 + {1'b0, c1_q.q}) : dif2[DW-1:0];
        if (c1_q.mode) begin
            x2_d = s2;
            p2_d = {{DW{1'b0}}, d2} * {{DW{1'b0}}, c1_q.w};
        end else begin
            x2_d = a1_q;
            p2_d = {{DW{1'b0}}, b1_q} * {{DW{1'b0}}, c1_q.w};
        end
    end

    // Restoring reduction: p < q*2^DW, so subtracting q<<k for k = DW-1..0 leaves p mod q.
    logic [2*DW-1:0] rem3;
    always_comb begin
        rem3 = p2_q;
        for (int k = DW - 1; k >= 0; k--) begin
            if (rem3 >= ({{DW{1'b0}}, c2_q.q} << k)) begin
                rem3 = rem3 - ({{DW{1'b0}}, c2_q.q} << k);
            end
        end
        r3_d = rem3[DW-1:0];
    end

    logic [DW:0]   sum4, dif4;
    logic [DW-1:0] ct_a, ct_b;
    always_comb begin
        sum4 = {1'b0, x3_q} + {1'b0, r3_q};
        ct_a = (sum4 >= {1'b0, c3_q.q}) ? DW'(sum4 - {1'b0, c3_q.q}) : sum4[DW-1:0];
        dif4 = {1'b0, x3_q} - {1'b0, r3_q};
        ct_b = dif4[DW] ? DW'(dif4 + {1'b0, c3_q.q}) : dif4[DW-1:0];
        if (c3_q.mode) begin
            fa_d = c3_q.div2 ? half_mod(x3_q, c3_q.q) : x3_q;
            fb_d = c3_q.div2 ? half_mod(r3_q, c3_q.q) : r3_q;
        end else begin
            fa_d = ct_a;
            fb_d = ct_b;
        end
    end

    // NOTE: sequential state uses <= so each stage samples its predecessor's pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            out_v_q <= 1'b0;
            fa_q    <= '0;
            fb_q    <= '0;
            tw_q    <= '0;
            md_q    <= '0;
        end else if (!bus.stall) begin
            v1_q    <= bus.in_valid;
            v2_q    <= v1_q;
            v3_q    <= v2_q;
            out_v_q <= v3_q;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            tw_q    <= c3_q.w;
            md_q    <= c3_q.q;
        end
    end

    // NOTE: internal datapath registers have no reset; their contents are don't-care while the stage valid is 0.
    always_ff @(posedge clk) begin
        if (!bus.stall) begin
            a1_q <= bus.in1;
            b1_q <= bus.in2;
            c1_q <= '{mode: bus.mode, div2: bus.div2, w: bus.twiddle, q: bus.modulus};
            x2_q <= x2_d;
            p2_q <= p2_d;
            c2_q <= c1_q;
            x3_q <= x2_q;
            r3_q <= r3_d;
            c3_q <= c2_q;
        end
    end

    assign bus.BU_valid       = out_v_q;
    assign bus.fft_a          = fa_q;
    assign bus.fft_b          = fb_q;
    assign bus.twiddle_BU_out = tw_q;
    assign bus.modulus_BU_out = md_q;
endmodule

// File: tb/tb_bu2_pipe_cfg.sv
// Self-checking bench for bu2_pipe_cfg: directed table, random streaming,
// stall/bubble and mid-stream reset, against a modular-arithmetic reference model.
module tb_bu2_pipe_cfg;
    localparam int DW = 16;

    logic clk, rst;
    bu2_pipe_cfg_if #(.DW(DW)) bus();
    bu2_pipe_cfg #(.DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        longint a, b, w, q;
        bit     mode, div2;
        longint exp_a, exp_b;
    } vec_t;

    typedef struct {
        longint fa, fb, w, q;
        int     cyc;
        int     stl;
    } exp_t;

    int     n_cmp = 0;
    int     n_fail = 0;
    exp_t   exp_q[$];
    int     cyc = 0;
    int     stall_cnt = 0;
    int     n_out = 0;
    int     first_out = -1;
    int     last_out = -1;
    int     n_lat7 = 0;
    longint qs[7] = '{3, 5, 257, 7681, 12289, 65521, 65535};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required finish before 100000");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference butterfly from the modular definitions; halving multiplies by 2^-1 = (q+1)/2.
    function automatic void model(input longint a, b, w, q, input bit mode, div2,
                                  output longint fa, output longint fb);
        longint t;
        if (!mode) begin
            t  = (b * w) % q;
            fa = (a + t) % q;
            fb = (a - t + q) % q;
        end else begin
            fa = (a + b) % q;
            fb = (((a - b + q) % q) * w) % q;
            if (div2) begin
                fa = (fa * ((q + 1) / 2)) % q;
                fb = (fb * ((q + 1) / 2)) % q;
            end
        end
    endfunction

    task automatic drive(input logic v, input longint a, b, w, q, input bit m, d);
        bus.in_valid = v;
        bus.in1      = DW'(a);
        bus.in2      = DW'(b);
        bus.twiddle  = DW'(w);
        bus.modulus  = DW'(q);
        bus.mode     = m;
        bus.div2     = d;
    endtask

    task automatic drive_rand();
        longint q;
        q = qs[$urandom_range(0, 6)];
        drive(1'b1, longint'($urandom) % q, longint'($urandom) % q, longint'($urandom) % q, q,
              1'($urandom), 1'($urandom));
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && exp_q.size() > 0; k++) @(posedge clk);
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin : cycle_counter
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Scoreboard: samples are consumed when BU_valid && !stall; latency is counted in non-stalled cycles.
    initial begin : monitor
        exp_t          e;
        longint        ea, eb;
        bit            prev_stall;
        logic          prev_v;
        logic [DW-1:0] prev_a, prev_b, prev_w, prev_q;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("frozen_valid", bus.BU_valid, prev_v);
                    check("frozen_a", bus.fft_a, prev_a);
                    check("frozen_b", bus.fft_b, prev_b);
                    check("frozen_w", bus.twiddle_BU_out, prev_w);
                    check("frozen_q", bus.modulus_BU_out, prev_q);
                end
                if (bus.BU_valid && !bus.stall) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_valid", bus.BU_valid, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_fft_a", bus.fft_a, e.fa);
                        check("sb_fft_b", bus.fft_b, e.fb);
                        check("sb_twiddle", bus.twiddle_BU_out, e.w);
                        check("sb_modulus", bus.modulus_BU_out, e.q);
                        check("sb_latency", (cyc - e.cyc) - (stall_cnt - e.stl), 4);
                        if (cyc - e.cyc == 7) n_lat7++;
                        if (first_out < 0) first_out = cyc;
                        last_out = cyc;
                        n_out++;
                    end
                end
                if (bus.in_valid && !bus.stall) begin
                    model(bus.in1, bus.in2, bus.twiddle, bus.modulus, bus.mode, bus.div2, ea, eb);
                    exp_q.push_back('{fa: ea, fb: eb, w: bus.twiddle, q: bus.modulus,
                                      cyc: cyc, stl: stall_cnt});
                end
                if (bus.stall) stall_cnt++;
                prev_stall = bus.stall;
                prev_v     = bus.BU_valid;
                prev_a     = bus.fft_a;
                prev_b     = bus.fft_b;
                prev_w     = bus.twiddle_BU_out;
                prev_q     = bus.modulus_BU_out;
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int lat;
        lat = -1;
        @(posedge clk); #1;
        drive(1'b1, v.a, v.b, v.w, v.q, v.mode, v.div2);
        @(negedge clk);
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            @(negedge clk);
            if (bus.BU_valid) lat = k;
        end
        check("vec_latency", lat, 4);
        check("vec_fft_a", bus.fft_a, v.exp_a);
        check("vec_fft_b", bus.fft_b, v.exp_b);
        check("vec_twiddle", bus.twiddle_BU_out, v.w);
        check("vec_modulus", bus.modulus_BU_out, v.q);
    endtask

    initial begin : main
        vec_t   tbl[10];
        int     issue0;
        int     n_iss;
        bit     hold;
        bit     st;
        longint ea, eb;

        tbl[0] = '{1, 2, 3, 7681, 0, 0, 7, 7676};
        tbl[1] = '{7680, 7680, 7680, 7681, 0, 0, 0, 7679};
        tbl[2] = '{0, 0, 5, 7681, 0, 0, 0, 0};
        tbl[3] = '{10, 3, 2, 7681, 1, 0, 13, 14};
        tbl[4] = '{10, 3, 2, 7681, 1, 1, 3847, 7};
        tbl[5] = '{3, 10, 1, 7681, 1, 0, 13, 7674};
        tbl[6] = '{1, 2, 3, 7681, 0, 1, 7, 7676};
        tbl[7] = '{2, 2, 2, 3, 0, 0, 0, 1};
        tbl[8] = '{65520, 65520, 65520, 65521, 1, 1, 65520, 0};
        tbl[9] = '{65534, 65534, 65534, 65535, 0, 0, 0, 65533};

        rst = 1'b0;
        bus.stall = 1'b0;
        drive(1'b0, 0, 0, 0, 3, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("reset_valid", bus.BU_valid, 1'b0);
        check("reset_fft_a", bus.fft_a, 0);
        check("reset_fft_b", bus.fft_b, 0);
        check("reset_twiddle", bus.twiddle_BU_out, 0);
        check("reset_modulus", bus.modulus_BU_out, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(tbl[i]);
        drain();

        // Back-to-back random stream.
        n_out = 0;
        first_out = -1;
        issue0 = 0;
        for (int i = 0; i < 96; i++) begin
            @(posedge clk); #1;
            drive_rand();
            if (i == 0) issue0 = cyc;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        drain();
        check("stream_count", n_out, 96);
        check("stream_first_latency", first_out - issue0, 4);
        check("stream_no_gaps", last_out - first_out + 1, 96);

        // Bubbles every 7th cycle, 3-cycle stall with the producer holding its vector.
        n_out = 0;
        n_lat7 = 0;
        n_iss = 0;
        hold = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(posedge clk); #1;
            st = (t >= 22 && t <= 24);
            if (!hold) begin
                if (t % 7 == 3) bus.in_valid = 1'b0;
                else drive_rand();
            end
            bus.stall = st;
            if (bus.in_valid && !st) n_iss++;
            hold = st;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.stall = 1'b0;
        drain();
        check("stall_count", n_out, n_iss);
        check("stall_stretched", n_lat7, 4);

        // Reset with three samples in flight and one on the outputs; stall held high too.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            drive_rand();
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        #2;
        check("pre_reset_valid", bus.BU_valid, 1'b1);
        rst = 1'b1;
        bus.stall = 1'b1;
        exp_q.delete();
        #1;
        check("async_reset_valid", bus.BU_valid, 1'b0);
        check("async_reset_fft_a", bus.fft_a, 0);
        check("async_reset_fft_b", bus.fft_b, 0);
        check("async_reset_twiddle", bus.twiddle_BU_out, 0);
        check("async_reset_modulus", bus.modulus_BU_out, 0);
        @(posedge clk); #1;
        check("reset_over_stall", bus.BU_valid, 1'b0);
        @(posedge clk); #1;
        bus.stall = 1'b0;
        drive(1'b1, 10, 3, 2, 7681, 1'b1, 1'b1);
        model(10, 3, 2, 7681, 1'b1, 1'b1, ea, eb);
        #2 rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k == 1) bus.in_valid = 1'b0;
            if (k < 4) check("no_stale_valid", bus.BU_valid, 1'b0);
        end
        check("post_reset_valid", bus.BU_valid, 1'b1);
        check("post_reset_fft_a", bus.fft_a, ea);
        check("post_reset_fft_b", bus.fft_b, eb);
        check("post_reset_twiddle", bus.twiddle_BU_out, 2);
        check("post_reset_modulus", bus.modulus_BU_out, 7681);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
